// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//   Single-clock FIFO that sits between sample capture and the packetiser /
//   readout path. It provides an occupancy count, almost-full and almost-empty
//   thresholds, and sticky overflow/underflow error flags.
//
//   Configuration macro FIFO_FWFT_EN:
//     undefined : dout is registered and updates on the edge that accepts a
//                 read, so read data arrives one cycle after rd_en.
//     defined   : first-word-fall-through. dout always shows the head word
//                 while the FIFO is not empty, and rd_en pops that word.
//
// Parameters
//   DATA_W    data word width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           asynchronous, active-high reset
//   wr_en, din    write request and write data
//   rd_en         read request (pops the head word in FWFT mode)
//   err_clr       clears the sticky overflow/underflow flags
//   dout          read data
//   empty, full, almost_empty, almost_full   level flags, decoded from count
//   count         number of stored words, 0..DEPTH
//   overflow      sticky: a write was attempted while full
//   underflow     sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Level flags come from the registered count only, never from this cycle's
  // requests, so they are stable for the whole cycle.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A full FIFO still accepts a read (and an empty one a write), so a
  // simultaneous request pair at a boundary is half accepted, half rejected.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Pointers wrap naturally at ADDR_W bits.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first, set second: a new error in the clearing cycle survives.
    if (err_clr)         overflow_d  = 1'b0;
    if (wr_en && full)   overflow_d  = 1'b1;
    if (err_clr)         underflow_d = 1'b0;
    if (rd_en && empty)  underflow_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once
  // the pointers and count are cleared, and leaving it out keeps it a plain
  // RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; don't-care when empty.
  assign dout = mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] dout_q;

  // Registered read port: loads only on an accepted read, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
  end

  assign dout = dout_q;
`endif

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow error flags. It is the next-generation data buffer between the sample-capture logic and the downstream packetiser/readout path. It replaces the fixed-flag buffer, adding threshold-driven flow control, error reporting and an optional first-word-fall-through read mode.

## Interface
Parameters:
- DATA_W, 64, data word width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W words
- AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- err_clr  in  1  clears overflow/underflow
- dout  out  DATA_W  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_W+1  words stored, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset values: count=0, wr_ptr=rd_ptr=0, dout=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for all legal values. Memory contents are not reset.
- Write accepted = wr_en && !full. A write stores din at wr_ptr, and wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Read accepted = rd_en && !empty. rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both are accepted or neither is.
- All four level flags are decoded combinationally from the registered count. They never depend on the same-cycle wr_en/rd_en.
- Full with wr_en=rd_en=1: read accepted, write rejected, overflow sets, count → DEPTH−1.
- Empty with wr_en=rd_en=1: write accepted, read rejected, underflow sets, count → 1.
- overflow/underflow set on any rejected request and hold until err_clr=1 at a clock edge. If set and clear happen in the same cycle, set wins.
- Rejected requests never change pointers, memory, count or dout.

## Timing
- Standard mode (macro undefined):
  - dout is registered and loads mem[rd_ptr] on the edge that accepts a read. Read latency is 1 cycle.
  - Otherwise dout holds its value, including while empty.
  - A write at edge N makes empty fall after edge N. rd_en in cycle N+1 presents the word on dout after edge N+1.
- Flags and count reflect the edge just taken (0-cycle lag from count).
- Asserting rst mid-operation immediately forces all reset values and discards stored data. The first accepted write after release lands at address 0.

## Configuration
- Macro FIFO_FWFT_EN.
- Undefined: standard mode as above.
- Defined: first-word-fall-through.
  - dout = mem[rd_ptr] combinationally whenever !empty. A write at edge N presents the word on dout after edge N.
  - rd_en acknowledges and pops the head word. The next word, if any, appears after that edge.
  - dout is don't-care while empty. Flags, count and error behaviour are identical to standard mode.
  - dout has no reset value in this mode.

## Test plan
Parameters for all scenarios: DATA_W=64, ADDR_W=5, AF_LEVEL=28, AE_LEVEL=2.
- Reset, then 32 writes of 0..31 → count=32, full=1, almost_full=1 from count 28; 32 reads → dout sequence 0..31 (1-cycle latency), empty=1.
- Fill to 32, then hold wr_en=rd_en=1 for 1 cycle → count=31, overflow=1, dout=oldest word. Pulse err_clr → overflow=0.
- Empty FIFO, wr_en=rd_en=1 with din=0xA5 → count=1, underflow=1. Next read → dout=0xA5.
- 20 writes, 20 reads, then 20 more writes and reads → pointers wrap past 31, data intact, almost_empty=1 exactly when count<=2.
- Fill to 10, assert rst for 1 cycle mid-burst → count=0, empty=1, dout=0, flags cleared. Then write 0x1 → dout=0x1 after read.
- With FIFO_FWFT_EN: write 0x77 at edge N → dout=0x77 and empty=0 after edge N. rd_en pops → empty=1.
